// File: rtl/mul16_wallace_seq_if.sv
// mul16_wallace_seq_if: request/result bundle between a requester and the sequential multiplier
interface mul16_wallace_seq_if;
  logic        start;
  logic        mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] z;
  modport master (output start, mode, a, b, input busy, done, z);
  modport slave  (input start, mode, a, b, output busy, done, z);
endinterface

// File: rtl/mul16_wallace_seq.sv
// mul16_wallace_seq: sequences one combinational 8x8 Wallace product unit into 16x16 or 8x8 unsigned multiplies
module wallace_8x8_product (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] p
);
  logic [15:0] r [8];
  logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
  function automatic logic [15:0] fa_s(logic [15:0] u, logic [15:0] v, logic [15:0] w);
    return u ^ v ^ w;
  endfunction
  function automatic logic [15:0] fa_c(logic [15:0] u, logic [15:0] v, logic [15:0] w);
    return ((u & v) | (u & w) | (v & w)) << 1;
  endfunction
  for (genvar i = 0; i < 8; i++) begin : g_row
    assign r[i] = {8'b0, x & {8{y[i]}}} << i;
  end
  // 8 rows -> 6 -> 4 -> 3 -> 2 through 3:2 compressor layers, then one carry-propagate add
  assign s0 = fa_s(r[0], r[1], r[2]);
  assign c0 = fa_c(r[0], r[1], r[2]);
  assign s1 = fa_s(r[3], r[4], r[5]);
  assign c1 = fa_c(r[3], r[4], r[5]);
  assign s2 = fa_s(s0, c0, s1);
  assign c2 = fa_c(s0, c0, s1);
  assign s3 = fa_s(c1, r[6], r[7]);
  assign c3 = fa_c(c1, r[6], r[7]);
  assign s4 = fa_s(s2, c2, s3);
  assign c4 = fa_c(s2, c2, s3);
  assign s5 = fa_s(s4, c4, c3);
  assign c5 = fa_c(s4, c4, c3);
  assign p  = s5 + c5;
endmodule

module mul16_wallace_seq (
  input logic clk,
  input logic clrn,
  mul16_wallace_seq_if.slave s
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [31:0] acc_q, acc_d, z_q, z_d, sum;
  logic [15:0] a_q, a_d, b_q, b_d, pp;
  logic        mode_q, mode_d, last;
  logic [7:0]  x, y;
  logic [4:0]  sh;
  wallace_8x8_product u_core (.x(x), .y(y), .p(pp));
  // step bit0 selects the high byte of a, bit1 the high byte of b
  assign x    = step_q[0] ? a_q[15:8] : a_q[7:0];
  assign y    = step_q[1] ? b_q[15:8] : b_q[7:0];
  assign sh   = step_q == 2'd0 ? 5'd0 : step_q == 2'd3 ? 5'd16 : 5'd8;
  assign sum  = acc_q + ({16'b0, pp} << sh);
  assign last = mode_q | (step_q == 2'd3);
  assign s.busy = state_q == MUL;
  assign s.done = state_q == DONE;
  assign s.z    = z_q;
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    z_d     = z_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    if (state_q != MUL) begin
      state_d = s.start ? MUL : IDLE;
      if (s.start) begin
        a_d    = s.a;
        b_d    = s.b;
        mode_d = s.mode;
        acc_d  = '0;
        step_d = '0;
      end
    end else begin
      acc_d   = sum;
      z_d     = last ? sum : z_q;
      state_d = last ? DONE : MUL;
      step_d  = last ? step_q : step_q + 2'd1;
    end
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      z_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
    end
  end
endmodule

// File: tb/tb_mul16_wallace_seq.sv
// tb_mul16_wallace_seq: directed table, back-to-back, abort and random sweep against an arithmetic reference
module tb_mul16_wallace_seq;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;
  mul16_wallace_seq_if bus();
  mul16_wallace_seq dut (.clk(clk), .clrn(clrn), .s(bus.slave));
  int total = 0;
  int bad = 0;
  logic [31:0] last_z = '0;
  typedef struct {
    logic        m;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] z;
  } vec_t;
  vec_t vecs[5];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic m, input logic [15:0] a, input logic [15:0] b);
    return m ? 32'(a[7:0]) * 32'(b[7:0]) : 32'(a) * 32'(b);
  endfunction
  always @(negedge clk) if (clrn) chk("busy_and_done", 32'(bus.busy & bus.done), 32'd0);
  // called at a negedge; returns at the negedge after the done cycle
  task automatic run_op(input logic m, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    int lat;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = ~m;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    lat = 1;
    chk("z_held_at_start", bus.z, last_z);
    while (!bus.done && lat < 10) begin
      chk("busy_in_mul", 32'(bus.busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
    chk("latency", 32'(lat), m ? 32'd2 : 32'd5);
    chk("busy_in_done", 32'(bus.busy), 32'd0);
    chk("z_result", bus.z, exp);
    last_z = exp;
    @(negedge clk);
    chk("done_single", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("z_hold_idle", bus.z, exp);
  endtask
  initial begin
    int lat;
    vecs[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[1] = '{1'b0, 16'h1234, 16'h5678, 32'h06260060};
    vecs[2] = '{1'b0, 16'h0000, 16'hABCD, 32'h00000000};
    vecs[3] = '{1'b1, 16'h12FF, 16'h34FF, 32'h0000FE01};
    vecs[4] = '{1'b1, 16'h0003, 16'h0002, 32'h00000006};
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_z", bus.z, 32'd0);
    clrn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_op(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].z);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.a     = 16'h0100;
    bus.b     = 16'h0100;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      lat = 1;
      while (!bus.done && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk("b2b_spacing", 32'(lat), 32'd5);
      chk("b2b_z", bus.z, k == 0 ? 32'h00010000 : 32'h000001FE);
      bus.mode = 1'b0;
      bus.a    = 16'h00FF;
      bus.b    = 16'h0002;
      bus.start = (k == 0);
    end
    @(negedge clk);
    chk("b2b_idle", 32'(bus.busy | bus.done), 32'd0);
    last_z = 32'h000001FE;
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("abort_z", bus.z, 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done | bus.busy), 32'd0);
    end
    last_z = '0;
    run_op(1'b0, 16'h0002, 16'h0003, 32'h00000006);
    for (int i = 0; i < 1000; i++) begin
      logic        m;
      logic [15:0] a, b;
      m = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      run_op(m, a, b, model(m, a, b));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
